// File: rtl/puf_pkg.sv
// Shared types and sizing helpers for the arbiter PUF evaluation controller.
package puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_FIRE  = 3'd2,
    ST_RELAX = 3'd3,
    ST_DONE  = 3'd4
  } puf_state_t;

  localparam int DEF_LENGTH       = 3;
  localparam int DEF_SETUP_CYCLES = 2;
  localparam int DEF_PULSE_CYCLES = 4;
  localparam int DEF_RELAX_CYCLES = 4;
  localparam int DEF_NUM_EVAL     = 5;

  function automatic int ones_width(input int num_eval);
    return (num_eval < 1) ? 1 : $clog2(num_eval + 1);
  endfunction

  // Phase counter must reach the longest of the three timed phases.
  function automatic int phase_width(input int setup, input int pulse, input int relax);
    int m;
    m = setup;
    if (pulse > m) m = pulse;
    if (relax > m) m = relax;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for signals crossing into the local clock domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Metastability settling chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= {WIDTH{1'b0}};
      sync_r <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/arbiter_puf_ctrl.sv
// Drives one arbiter PUF through repeated evaluations of a challenge and
// returns the majority-voted response with the count of ones.
module arbiter_puf_ctrl
  import puf_pkg::*;
#(
  parameter int C_LENGTH       = DEF_LENGTH,
  parameter int C_SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int C_PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int C_RELAX_CYCLES = DEF_RELAX_CYCLES,
  parameter int C_NUM_EVAL     = DEF_NUM_EVAL
) (
  input  logic                                iclk,
  input  logic                                irst_n,
  input  logic                                ichallenge_valid,
  input  logic [C_LENGTH-1:0]                 ichallenge,
  output logic                                ochallenge_ready,
  output logic                                opuf_pulse,
  output logic [C_LENGTH-1:0]                 opuf_challenge,
  input  logic                                ipuf_response,
  output logic                                oresponse_valid,
  output logic                                oresponse,
  output logic [ones_width(C_NUM_EVAL)-1:0]   oones_count,
  input  logic                                iresponse_ready
);

  localparam int ONES_W = ones_width(C_NUM_EVAL);
  localparam int PH_W   = phase_width(C_SETUP_CYCLES, C_PULSE_CYCLES, C_RELAX_CYCLES);

  puf_state_t        state_r;
  logic [PH_W-1:0]   phase_r;
  logic [ONES_W-1:0] eval_r;
  logic [ONES_W-1:0] ones_r;
  logic              resp_sync_s;

  sync_2ff #(.WIDTH(1)) u_resp_sync (
    .clk   (iclk),
    .rst_n (irst_n),
    .d     (ipuf_response),
    .q     (resp_sync_s)
  );

  // Evaluation sequencer; every output comes straight from a flop so the
  // pulse edge seen by the PUF is glitch-free.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_r          <= ST_IDLE;
      phase_r          <= PH_W'(0);
      eval_r           <= ONES_W'(0);
      ones_r           <= ONES_W'(0);
      opuf_pulse       <= 1'b0;
      opuf_challenge   <= {C_LENGTH{1'b0}};
      ochallenge_ready <= 1'b1;
      oresponse_valid  <= 1'b0;
      oresponse        <= 1'b0;
      oones_count      <= ONES_W'(0);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ichallenge_valid && ochallenge_ready) begin
            opuf_challenge   <= ichallenge;
            ochallenge_ready <= 1'b0;
            phase_r          <= PH_W'(0);
            eval_r           <= ONES_W'(0);
            ones_r           <= ONES_W'(0);
            state_r          <= ST_ARM;
          end else begin
            ochallenge_ready <= 1'b1;
          end
        end
        ST_ARM: begin
          if (phase_r == PH_W'(C_SETUP_CYCLES - 1)) begin
            phase_r    <= PH_W'(0);
            opuf_pulse <= 1'b1;
            state_r    <= ST_FIRE;
          end else begin
            phase_r <= phase_r + PH_W'(1);
          end
        end
        ST_FIRE: begin
          // Last high cycle: the synchronized response has had time to settle.
          if (phase_r == PH_W'(C_PULSE_CYCLES - 1)) begin
            phase_r    <= PH_W'(0);
            opuf_pulse <= 1'b0;
            ones_r     <= ones_r + ONES_W'(resp_sync_s);
            state_r    <= ST_RELAX;
          end else begin
            phase_r <= phase_r + PH_W'(1);
          end
        end
        ST_RELAX: begin
          if (phase_r == PH_W'(C_RELAX_CYCLES - 1)) begin
            phase_r <= PH_W'(0);
            eval_r  <= eval_r + ONES_W'(1);
            if (eval_r == ONES_W'(C_NUM_EVAL - 1)) begin
              oresponse_valid <= 1'b1;
              oresponse       <= (ones_r > ONES_W'(C_NUM_EVAL / 2));
              oones_count     <= ones_r;
              state_r         <= ST_DONE;
            end else begin
              opuf_pulse <= 1'b1;
              state_r    <= ST_FIRE;
            end
          end else begin
            phase_r <= phase_r + PH_W'(1);
          end
        end
        ST_DONE: begin
          if (iresponse_ready) begin
            oresponse_valid  <= 1'b0;
            ochallenge_ready <= 1'b1;
            state_r          <= ST_IDLE;
          end else begin
            oresponse_valid <= 1'b1;
          end
        end
        default: begin
          state_r          <= ST_IDLE;
          phase_r          <= PH_W'(0);
          opuf_pulse       <= 1'b0;
          ochallenge_ready <= 1'b1;
          oresponse_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/arbiter_puf_ctrl.md
# arbiter_puf_ctrl

- Evaluation controller sitting directly upstream of `arbiter_puf`.
- Accepts a challenge over a valid/ready handshake and drives `ipulse`/`ichallenge` of the PUF with glitch-free registered timing.
- Samples the asynchronous `oresponse` through a synchronizer and repeats the evaluation `C_NUM_EVAL` times.
- Returns the majority-voted response bit plus the ones count over a valid/ready handshake.

## Interface

Parameters:
- `C_LENGTH`, 3: challenge width; must match the attached `arbiter_puf`.
- `C_SETUP_CYCLES`, 2: cycles the challenge is stable with pulse low before the first rising edge; ≥1.
- `C_PULSE_CYCLES`, 4: cycles the pulse is held high per evaluation; ≥3.
- `C_RELAX_CYCLES`, 4: cycles the pulse is held low after each evaluation; ≥1.
- `C_NUM_EVAL`, 5: evaluations per challenge; odd, ≥1.

Ports:
- `iclk`, in, 1: single clock.
- `irst_n`, in, 1: reset; asynchronous, active-low.
- `ichallenge_valid`, in, 1: challenge offered.
- `ichallenge`, in, `C_LENGTH`: challenge value.
- `ochallenge_ready`, out, 1: controller idle; accepts the challenge.
- `opuf_pulse`, out, 1: to `arbiter_puf.ipulse`; driven directly from a flop.
- `opuf_challenge`, out, `C_LENGTH`: to `arbiter_puf.ichallenge`; registered.
- `ipuf_response`, in, 1: from `arbiter_puf.oresponse`; asynchronous to `iclk`.
- `oresponse_valid`, out, 1: result available.
- `oresponse`, out, 1: majority vote.
- `oones_count`, out, `$clog2(C_NUM_EVAL+1)`: number of evaluations that returned 1.
- `iresponse_ready`, in, 1: consumer takes the result.

## Operation

- FSM states: IDLE, ARM, FIRE, RELAX, DONE.
- IDLE:
  - `ochallenge_ready`=1.
  - On `ichallenge_valid`&&ready: register `ichallenge` into `opuf_challenge`, clear the ones counter and eval counter, go to ARM.
- ARM: pulse low for `C_SETUP_CYCLES`, then go to FIRE.
- FIRE:
  - Pulse high for `C_PULSE_CYCLES`.
  - On the last FIRE cycle, add the synchronized response bit to the ones counter.
  - Go to RELAX.
- RELAX:
  - Pulse low for `C_RELAX_CYCLES`.
  - Then increment the eval counter.
  - If the counter equals `C_NUM_EVAL`, go to DONE; otherwise go to FIRE. ARM is not repeated.
- DONE:
  - `oresponse_valid`=1.
  - `oresponse` = (ones > `C_NUM_EVAL`/2).
  - Hold the result until `iresponse_ready`, then go to IDLE.
- `opuf_challenge` holds its value from acceptance until the next acceptance; it never changes while pulse is high.
- `ichallenge_valid` is ignored outside IDLE (ready=0); no queueing.
- The ones counter saturates by construction; it never exceeds `C_NUM_EVAL`.
- `ipuf_response` passes through a 2-flop synchronizer and is used nowhere else.

## Timing

- Reset values:
  - state IDLE, `opuf_pulse`=0, `opuf_challenge`=0.
  - `oresponse_valid`=0, `oresponse`=0, `oones_count`=0.
  - `ochallenge_ready`=1, synchronizer flops=0.
- Reset asserted mid-operation: `opuf_pulse` drops immediately (async); any pending result is discarded.
- Acceptance edge = E0:
  - `opuf_pulse` rises at edge E(`C_SETUP_CYCLES`).
  - Eval k (0-based) is high from edge E(S+k·(P+R)) to E(S+k·(P+R)+P), where S=`C_SETUP_CYCLES`, P=`C_PULSE_CYCLES`, R=`C_RELAX_CYCLES`.
- `oresponse_valid` rises at edge E(S+`C_NUM_EVAL`·(P+R)); with defaults this is E42.
- Handshake:
  - The result transfers on the edge where valid&&`iresponse_ready`.
  - `ochallenge_ready` rises on that same edge.
  - A new challenge is accepted at the earliest one edge later.
- The response sample on the last FIRE cycle reflects the PUF output at least 2 cycles after the rising pulse edge; this is why P≥3.

## Structure

- Shared package `puf_pkg`:
  - State enum for IDLE/ARM/FIRE/RELAX/DONE.
  - Default timing constants.
  - A function returning the ones-count width.
- Sub-module `sync_2ff`: generic 2-flop synchronizer with async active-low reset. Reused for any other PUF output crossing into `iclk`.
- Top-level integration instantiates `arbiter_puf_ctrl` and `arbiter_puf` side by side.

## Test plan

The bench uses a behavioural PUF model: `oresponse` takes a scripted bit 1 ns after each pulse rise.

- **Reset values:** release reset → all outputs at reset values; `ochallenge_ready`=1; pulse stays 0 for 100 cycles.
- **All-ones model:** challenge 3'b101 → `opuf_challenge`=3'b101; 5 pulses each 4 cycles high and 4 low, first rise at E2; `oresponse_valid` at E42 with `oresponse`=1, `oones_count`=5.
- **Majority zero:** model scripted 1,0,1,0,0 → `oones_count`=2, `oresponse`=0.
- **Backpressure and busy:**
  - `iresponse_ready` low for 10 cycles after valid → outputs held constant, `ochallenge_ready`=0.
  - Ready high → IDLE next edge.
  - A second `ichallenge_valid` offered mid-evaluation is not accepted and does not alter `opuf_challenge`.
- **Reset mid-FIRE:** assert `irst_n`=0 during the third pulse → `opuf_pulse`=0 without waiting for a clock edge; after release, no `oresponse_valid` appears; a fresh challenge completes normally.
- **Parameter corner:** `C_NUM_EVAL`=1 and `C_PULSE_CYCLES`=3 → valid at E(2+7)=E9 with a single sampled bit.
